// File: rtl/jk_bank_arbiter.sv
// Two-requester round-robin arbiter that owns a bank of WIDTH JK flip-flops.
// Each grant runs one masked JK command, then holds ACK until the request drops.

module jk_bank_cell (
    input  logic       q,
    input  logic       sel,
    input  logic [1:0] op,
    output logic       q_next
);
    always_comb begin
        q_next = q;
        if (sel) begin
            case (op)
                2'b01:   q_next = 1'b0;
                2'b10:   q_next = 1'b1;
                2'b11:   q_next = ~q;
                default: q_next = q;
            endcase
        end
    end
endmodule

module jk_bank_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             REQ0,
    input  logic [1:0]       OP0,
    input  logic [WIDTH-1:0] MASK0,
    input  logic             REQ1,
    input  logic [1:0]       OP1,
    input  logic [WIDTH-1:0] MASK1,
    output logic             ACK0,
    output logic             ACK1,
    output logic [1:0]       GNT,
    output logic             BUSY,
    output logic [WIDTH-1:0] Q
);
    typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, DONE = 2'd2} state_t;

    state_t           state_q, state_d;
    logic [1:0]       gnt_q, gnt_d;
    logic             last_q, last_d;
    logic [1:0]       op_q, op_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] q_upd;
    logic             pick1;

    for (genvar g = 0; g < WIDTH; g++) begin : g_cell
        jk_bank_cell u_cell (
            .q      (q_q[g]),
            .sel    (mask_q[g]),
            .op     (op_q),
            .q_next (q_upd[g])
        );
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= IDLE;
            gnt_q   <= 2'b00;
            last_q  <= 1'b1;
            op_q    <= 2'b00;
            mask_q  <= '0;
            q_q     <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            op_q    <= op_d;
            mask_q  <= mask_d;
            q_q     <= q_d;
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        op_d    = op_q;
        mask_d  = mask_q;
        q_d     = q_q;
        // Requester 1 wins alone, or on a tie when requester 0 was served last.
        pick1   = REQ1 && (!REQ0 || !last_q);
        case (state_q)
            IDLE: begin
                if (REQ0 || REQ1) begin
                    state_d = EXEC;
                    gnt_d   = pick1 ? 2'b10 : 2'b01;
                    last_d  = pick1;
                    op_d    = pick1 ? OP1 : OP0;
                    mask_d  = pick1 ? MASK1 : MASK0;
                end
            end
            EXEC: begin
                q_d     = q_upd;
                state_d = DONE;
            end
            DONE: begin
                if (!(gnt_q[0] ? REQ0 : REQ1)) begin
                    state_d = IDLE;
                    gnt_d   = 2'b00;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ACK0 = (state_q == DONE) && gnt_q[0];
        ACK1 = (state_q == DONE) && gnt_q[1];
        GNT  = gnt_q;
        BUSY = (state_q != IDLE);
        Q    = q_q;
    end
endmodule

// File: tb/tb_jk_bank_arbiter.sv
// Directed bench for jk_bank_arbiter: a transaction-level model checked every
// cycle, plus literal expectations at the key points of each scenario.

module tb_jk_bank_arbiter;
    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic       REQ0 = 1'b0, REQ1 = 1'b0;
    logic [1:0] OP0 = 2'b00, OP1 = 2'b00;
    logic [7:0] MASK0 = 8'h00, MASK1 = 8'h00;
    logic       ACK0, ACK1, BUSY;
    logic [1:0] GNT;
    logic [7:0] Q;

    int n_chk = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    jk_bank_arbiter #(.WIDTH(8)) dut (
        .CLK(CLK), .RESET(RESET),
        .REQ0(REQ0), .OP0(OP0), .MASK0(MASK0),
        .REQ1(REQ1), .OP1(OP1), .MASK1(MASK1),
        .ACK0(ACK0), .ACK1(ACK1), .GNT(GNT), .BUSY(BUSY), .Q(Q)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: who owns the bank and how many edges since the grant.
    int         m_owner = -1;
    int         m_age = 0;
    int         m_last = 1;
    logic [1:0] m_op = 2'b00;
    logic [7:0] m_mask = 8'h00;
    logic [7:0] m_q = 8'h00;
    int         grant_log[$];

    function automatic logic [7:0] jk_apply(input logic [7:0] q, input logic [1:0] op, input logic [7:0] m);
        case (op)
            2'b01:   return q & ~m;
            2'b10:   return q | m;
            2'b11:   return q ^ m;
            default: return q;
        endcase
    endfunction

    always @(posedge CLK) begin
        if (RESET) begin
            m_owner <= -1;
            m_age   <= 0;
            m_q     <= 8'h00;
            m_last  <= 1;
        end else if (m_owner < 0) begin
            if (REQ0 || REQ1) begin
                automatic int w = (REQ0 && REQ1) ? 1 - m_last : (REQ0 ? 0 : 1);
                m_owner <= w;
                m_age   <= 0;
                m_last  <= w;
                m_op    <= (w == 0) ? OP0 : OP1;
                m_mask  <= (w == 0) ? MASK0 : MASK1;
                grant_log.push_back(w);
            end
        end else if (m_age == 0) begin
            m_q   <= jk_apply(m_q, m_op, m_mask);
            m_age <= 1;
        end else if (((m_owner == 0) ? REQ0 : REQ1) == 1'b0) begin
            m_owner <= -1;
            m_age   <= 0;
        end
    end

    always @(negedge CLK) begin
        if (chk_en) begin
            check("cyc_gnt", {30'd0, GNT}, (m_owner == 0) ? 2'b01 : (m_owner == 1) ? 2'b10 : 2'b00);
            check("cyc_ack0", {31'd0, ACK0}, (m_owner == 0 && m_age == 1) ? 1 : 0);
            check("cyc_ack1", {31'd0, ACK1}, (m_owner == 1 && m_age == 1) ? 1 : 0);
            check("cyc_busy", {31'd0, BUSY}, (m_owner >= 0) ? 1 : 0);
            check("cyc_q", {24'd0, Q}, {24'd0, m_q});
        end
    end

    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
    endtask

    task automatic set_req(input int n, input logic v, input logic [1:0] op, input logic [7:0] m);
        if (n == 0) begin REQ0 = v; OP0 = op; MASK0 = m; end
        else        begin REQ1 = v; OP1 = op; MASK1 = m; end
    endtask

    // Wait (bounded) for ACKn; returns the observed ACK level.
    task automatic wait_ack(input int n, output logic ack);
        int cyc = 0;
        ack = (n == 0) ? ACK0 : ACK1;
        while (!ack && cyc < 20) begin
            tick();
            cyc++;
            ack = (n == 0) ? ACK0 : ACK1;
        end
    endtask

    task automatic txn(input int n, input logic [1:0] op, input logic [7:0] m);
        logic ack;
        set_req(n, 1'b1, op, m);
        wait_ack(n, ack);
        check("txn_ack", {31'd0, ack}, 1);
        set_req(n, 1'b0, op, m);
        tick();
    endtask

    initial begin
        logic ack;
        int   order[$];
        tick();
        chk_en = 1'b1;
        tick();
        check("rst_q", {24'd0, Q}, 0);
        check("rst_gnt", {30'd0, GNT}, 0);
        check("rst_busy", {31'd0, BUSY}, 0);
        RESET = 1'b0;

        // Basic set with fixed latency.
        set_req(0, 1'b1, 2'b10, 8'h0F);
        tick();
        check("lat_gnt", {30'd0, GNT}, 2'b01);
        check("lat_ack_early", {31'd0, ACK0}, 0);
        tick();
        check("lat_q", {24'd0, Q}, 8'h0F);
        check("lat_ack", {31'd0, ACK0}, 1);
        tick();
        check("hold_ack", {31'd0, ACK0}, 1);
        set_req(0, 1'b0, 2'b10, 8'h0F);
        tick();
        check("drop_ack", {31'd0, ACK0}, 0);
        check("drop_gnt", {30'd0, GNT}, 0);
        check("drop_busy", {31'd0, BUSY}, 0);

        // Toggle then clear.
        txn(1, 2'b11, 8'hFF);
        check("toggle_q", {24'd0, Q}, 8'hF0);
        txn(0, 2'b01, 8'h30);
        check("clear_q", {24'd0, Q}, 8'hC0);
        txn(1, 2'b11, 8'h00);
        check("mask0_q", {24'd0, Q}, 8'hC0);

        // Simultaneous requests: round-robin, both re-requesting.
        do_reset();
        set_req(0, 1'b1, 2'b10, 8'h01);
        set_req(1, 1'b1, 2'b10, 8'h80);
        grant_log.delete();
        for (int k = 0; k < 4; k++) begin
            int cyc = 0;
            while (!ACK0 && !ACK1 && cyc < 20) begin
                tick();
                cyc++;
            end
            check("rr_ack_seen", {31'd0, ACK0 | ACK1}, 1);
            order.push_back(ACK1 ? 1 : 0);
            if (k == 1) check("rr_q", {24'd0, Q}, 8'h81);
            if (ACK1) REQ1 = 1'b0; else REQ0 = 1'b0;
            tick();
            REQ0 = 1'b1;
            REQ1 = 1'b1;
        end
        check("rr_count", order.size(), 4);
        for (int k = 0; k < 4 && k < order.size(); k++)
            check("rr_order", order[k], k % 2);
        check("rr_log_0", (grant_log.size() > 0) ? grant_log[0] : 9, 0);
        check("rr_log_1", (grant_log.size() > 1) ? grant_log[1] : 9, 1);
        REQ0 = 1'b0;
        REQ1 = 1'b0;
        for (int k = 0; k < 6; k++) begin
            if (ACK0 || ACK1 || !BUSY) break;
            tick();
        end
        for (int k = 0; k < 6 && BUSY; k++) begin
            REQ0 = 1'b0;
            REQ1 = 1'b0;
            tick();
        end
        check("rr_idle", {31'd0, BUSY}, 0);

        // Hold op completes handshake with Q unchanged.
        do_reset();
        txn(0, 2'b10, 8'h5A);
        check("pre_hold_q", {24'd0, Q}, 8'h5A);
        txn(0, 2'b00, 8'hFF);
        check("hold_q", {24'd0, Q}, 8'h5A);

        // Operands changed after the grant edge are ignored.
        do_reset();
        set_req(0, 1'b1, 2'b10, 8'h01);
        tick();
        MASK0 = 8'hFF;
        OP0 = 2'b11;
        tick();
        check("latch_q", {24'd0, Q}, 8'h01);
        set_req(0, 1'b0, 2'b10, 8'hFF);
        tick();

        // Reset on the EXEC edge aborts the op; REQ1 is re-granted afterwards.
        do_reset();
        set_req(1, 1'b1, 2'b10, 8'hFF);
        tick();
        check("abort_gnt", {30'd0, GNT}, 2'b10);
        RESET = 1'b1;
        tick();
        check("abort_q", {24'd0, Q}, 8'h00);
        check("abort_ack", {31'd0, ACK1}, 0);
        check("abort_busy", {31'd0, BUSY}, 0);
        RESET = 1'b0;
        tick();
        check("regrant_gnt", {30'd0, GNT}, 2'b10);
        wait_ack(1, ack);
        check("regrant_ack", {31'd0, ack}, 1);
        check("regrant_q", {24'd0, Q}, 8'hFF);
        set_req(1, 1'b0, 2'b10, 8'hFF);
        tick();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
